mem_rr_arbiter: RTL

//  Round-robin arbiter sharing one Memory_synth instance (combinational read, clocked write)

---
 rtl/mem_rr_arbiter_if.sv | 40 ++++
 rtl/mem_rr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if
//   Requester-side bus of the shared-memory round-robin arbiter. The four
//   requesters are packed side by side in each vector: requester i owns
//   bit i of req/we_req/lock/gnt/rvalid, addr_req[i*AW +: AW] and
//   wdata_req[i*DW +: DW].
// Signals
//   req        4      request, held with stable fields until served
//   we_req     4      1 = write, 0 = read
//   lock       4      ask to keep the grant for a burst
//   addr_req   4*AW   per-requester address
//   wdata_req  4*DW   per-requester write data
//   gnt        4      one-hot grant, high during the owner's access cycle
//   rvalid     4      one-cycle pulse, rdata valid for requester i
//   rdata      DW     registered read data shared by all requesters
// Modports
//   master     requester side (drives requests, receives grants/data)
//   slave      arbiter side
interface mem_rr_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic [3:0]      req;
  logic [3:0]      we_req;
  logic [3:0]      lock;
  logic [4*AW-1:0] addr_req;
  logic [4*DW-1:0] wdata_req;
  logic [3:0]      gnt;
  logic [3:0]      rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, we_req, lock, addr_req, wdata_req,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we_req, lock, addr_req, wdata_req,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Round-robin arbiter sharing one memory (combinational read, clocked
//   write) between four requesters. One requester owns the memory port per
//   ACCESS cycle; read data comes back registered one cycle later. A
//   requester holding lock keeps the grant for up to BURST_MAX consecutive
//   cycles before it is forced to rotate.
// Ports
//   clock      in   single clock, all state on posedge
//   reset_L    in   synchronous reset, active low
//   bus        slave modport of mem_rr_arbiter_if (requests, grants, rdata)
//   busy       out  arbiter is in ACCESS
//   mem_re     out  memory read enable
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_rdata  in   memory read data (combinational)
module mem_rr_arbiter #(
  parameter int DW        = 8,
  parameter int W         = 16,
  parameter int AW        = $clog2(W),
  parameter int BURST_MAX = 4
) (
  input  logic          clock,
  input  logic          reset_L,
  mem_rr_arbiter_if.slave bus,
  output logic          busy,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [1:0]    owner;
  logic [1:0]    ptr;
  logic [CW-1:0] burst_cnt;

  logic          owner_req;
  logic          owner_we;
  logic          burst_more;
  logic [1:0]    arb_start;
  logic [1:0]    winner;

  // Rotate the request vector so that 'start' lands at bit 0, take the
  // lowest set bit, then rotate the offset back.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;
    dbl = {r, r} >> start;
    rot = dbl[3:0];
    casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      default: off = 2'd3;
    endcase
    return start + off;
  endfunction

  always_comb begin
    owner_req  = bus.req[owner];
    owner_we   = bus.we_req[owner];
    burst_more = int'(burst_cnt) < (BURST_MAX - 1);
    // From IDLE the search starts at ptr; when leaving ACCESS it starts just
    // past the owner, which is where ptr is being moved to on that edge.
    arb_start  = (state == ACCESS) ? owner + 2'd1 : ptr;
    winner     = rr_pick(bus.req, arb_start);
  end

  // Enables are gated by reset_L so a write can never land in a reset cycle,
  // even when reset hits in the middle of a locked burst.
  always_comb begin
    busy      = (state == ACCESS);
    mem_addr  = bus.addr_req[owner*AW +: AW];
    mem_wdata = bus.wdata_req[owner*DW +: DW];
    mem_we    = reset_L & (state == ACCESS) & owner_req & owner_we;
    mem_re    = reset_L & (state == ACCESS) & owner_req & ~owner_we;
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state      <= IDLE;
      owner      <= 2'd0;
      ptr        <= 2'd0;
      burst_cnt  <= '0;
      bus.gnt    <= 4'b0000;
      bus.rvalid <= 4'b0000;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= 4'b0000;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            owner     <= winner;
            bus.gnt   <= 4'b0001 << winner;
            burst_cnt <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // A withdrawn request (owner_req low) still burns the cycle.
          if (owner_req && !owner_we) begin
            bus.rdata  <= mem_rdata;
            bus.rvalid <= 4'b0001 << owner;
          end
          if (bus.lock[owner] && owner_req && burst_more) begin
            burst_cnt <= burst_cnt + CW'(1);
          end else begin
            ptr <= owner + 2'd1;
            if (|bus.req) begin
              owner     <= winner;
              bus.gnt   <= 4'b0001 << winner;
              burst_cnt <= '0;
            end else begin
              bus.gnt <= 4'b0000;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
